ifetch_unit: RTL and testbench

Instruction fetch stage of the RV32 core. It owns the PC, fetches instructions from instruction memory over a valid/ready handshake, and presents one instruction at a time to decode/execute. It is the consumer of the execute stage's branch decision. On each accepted instruction it takes back the branch condition (ALU `zero`), the immediate, the jump flags and the ALU result, and computes the next PC from them.

---
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// RV32 instruction fetch stage: owns the PC, fetches over a valid/ready memory
// handshake, holds one instruction for downstream and resolves the next PC on accept.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        inst_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm32,
    input  logic [31:0] alu_result,
    input  logic        halt,
    output logic        misalign_fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_retired;
    logic [31:0] w_next_pc;
    logic [31:0] w_jalr_target;
    logic        w_accept;
    logic        w_fetch_done;
    logic        w_misalign;

    assign w_accept      = (r_state == S_VALID) && inst_ready;
    assign w_fetch_done  = (r_state == S_FETCH) && imem_ready;
    assign w_jalr_target = alu_result & ~32'h0000_0001;

    // jalr outranks jal, which outranks a taken branch
    always_comb begin
        if (jalr) begin
            w_next_pc = w_jalr_target;
        end else if (jal || (branch && zero)) begin
            w_next_pc = r_pc + imm32;
        end else begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    assign w_misalign = (w_next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        imem_req       = 1'b0;
        inst_valid     = 1'b0;
        misalign_fault = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_next_state = S_VALID;
                end
            end
            S_VALID: begin
                inst_valid = 1'b1;
                // a misaligned target wins over halt
                if (inst_ready) begin
                    if (w_misalign) begin
                        w_next_state = S_FAULT;
                    end else if (halt) begin
                        w_next_state = S_HALT;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            S_FAULT: begin
                misalign_fault = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_retired <= 32'h0;
        end else begin
            if (w_fetch_done) begin
                r_inst <= imem_rdata;
            end
            if (w_accept) begin
                r_retired <= r_retired + 32'd1;
                // keep the last good pc when the target is misaligned
                if (!w_misalign) begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = r_pc + 32'd4;
    assign inst      = r_inst;
    assign retired   = r_retired;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: boot, wait states, branches, jumps,
// backpressure, halt, misalign fault and asynchronous reset.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_ready;
    logic        branch;
    logic        zero;
    logic        jal;
    logic        jalr;
    logic [31:0] imm32;
    logic [31:0] alu_result;
    logic        halt;
    logic        misalign_fault;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
        .inst_ready(inst_ready), .branch(branch), .zero(zero),
        .jal(jal), .jalr(jalr), .imm32(imm32), .alu_result(alu_result),
        .halt(halt), .misalign_fault(misalign_fault), .retired(retired)
    );

    always #5 clk = ~clk;

    // Memory image: each word carries its own address in the low half.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl;
        branch = 0; zero = 0; jal = 0; jalr = 0;
        imm32 = 0; alu_result = 0; halt = 0;
    endtask

    task automatic do_accept(input logic br, input logic z, input logic j, input logic jr,
                             input logic [31:0] imm, input logic [31:0] alu, input logic h);
        branch = br; zero = z; jal = j; jalr = jr;
        imm32 = imm; alu_result = alu; halt = h;
        inst_ready = 1;
        tick();
        clear_ctrl();
        inst_ready = 0;
    endtask

    task automatic do_fetch;
        imem_ready = 1;
        tick();
        imem_ready = 0;
    endtask

    task automatic test_reset;
        rst = 0;
        #2 rst = 1;
        #2;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL rst_pc got=%h exp=00000100", pc); end
        n_tests++; if (pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL rst_pc4 got=%h exp=00000104", pc_plus4); end
        n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got=%h exp=0", inst); end
        n_tests++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got=%b exp=0", misalign_fault); end
        n_tests++; if (retired !== 32'h0) begin n_fail++; $display("FAIL rst_retired got=%h exp=0", retired); end
        imem_ready = 1;
        tick(); tick();
        rst = 0;
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL boot_fetch req=%b addr=%h valid=%b exp 1/00000100/0", imem_req, imem_addr, inst_valid); end
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst !== 32'hC0DE_0100 || pc !== 32'h100 || pc_plus4 !== 32'h104 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL boot_valid valid=%b inst=%h pc=%h pc4=%h req=%b exp 1/c0de0100/100/104/0", inst_valid, inst, pc, pc_plus4, imem_req); end
        imem_ready = 0;
    endtask

    task automatic test_wait_states;
        logic [31:0] cur;
        logic [31:0] nxt;
        for (int i = 0; i < 2; i++) begin
            cur = (i == 0) ? 32'h100 : 32'h104;
            nxt = (i == 0) ? 32'h104 : 32'h108;
            tick();
            n_tests++; if (inst_valid !== 1'b1 || pc !== cur || inst !== {16'hC0DE, cur[15:0]} || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL hold_valid valid=%b pc=%h inst=%h req=%b exp pc=%h", inst_valid, pc, inst, imem_req, cur); end
            do_accept(0, 0, 0, 0, 32'h0, 32'h0, 0);
            n_tests++; if (retired !== 32'(i + 1) || imem_req !== 1'b1 || imem_addr !== nxt) begin
                n_fail++; $display("FAIL seq_accept retired=%h req=%b addr=%h exp %0d/1/%h", retired, imem_req, imem_addr, i + 1, nxt); end
            for (int w = 0; w < 3; w++) begin
                tick();
                n_tests++; if (imem_req !== 1'b1 || imem_addr !== nxt || inst_valid !== 1'b0) begin
                    n_fail++; $display("FAIL wait_state req=%b addr=%h valid=%b exp 1/%h/0", imem_req, imem_addr, inst_valid, nxt); end
            end
            do_fetch();
            n_tests++; if (inst_valid !== 1'b1 || inst !== {16'hC0DE, nxt[15:0]} || pc !== nxt) begin
                n_fail++; $display("FAIL seq_valid valid=%b inst=%h pc=%h exp 1/pc=%h", inst_valid, inst, pc, nxt); end
        end
    endtask

    task automatic test_branch;
        do_accept(1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0);
        n_tests++; if (imem_addr !== 32'h100 || retired !== 32'd3) begin
            n_fail++; $display("FAIL br_taken addr=%h retired=%h exp 00000100/3", imem_addr, retired); end
        do_fetch();
        do_accept(0, 0, 0, 0, 32'h0, 32'h0, 0);
        do_fetch();
        do_accept(0, 0, 0, 0, 32'h0, 32'h0, 0);
        do_fetch();
        n_tests++; if (pc !== 32'h108) begin n_fail++; $display("FAIL br_setup pc=%h exp 00000108", pc); end
        do_accept(1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 0);
        n_tests++; if (imem_addr !== 32'h10C || retired !== 32'd6) begin
            n_fail++; $display("FAIL br_not_taken addr=%h retired=%h exp 0000010c/6", imem_addr, retired); end
        do_fetch();
    endtask

    task automatic test_jumps;
        do_accept(0, 0, 1, 0, 32'hFFFF_FFF4, 32'h0, 0);
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL jal_back addr=%h exp 00000100", imem_addr); end
        do_fetch();
        do_accept(0, 0, 1, 0, 32'h20, 32'h0, 0);
        n_tests++; if (imem_addr !== 32'h120) begin n_fail++; $display("FAIL jal_fwd addr=%h exp 00000120", imem_addr); end
        do_fetch();
        n_tests++; if (pc_plus4 !== 32'h124) begin n_fail++; $display("FAIL jal_link pc4=%h exp 00000124", pc_plus4); end
        do_accept(0, 0, 1, 1, 32'h40, 32'h205, 0);
        n_tests++; if (imem_addr !== 32'h204 || retired !== 32'd9) begin
            n_fail++; $display("FAIL jalr_prio addr=%h retired=%h exp 00000204/9", imem_addr, retired); end
        do_fetch();
    endtask

    task automatic test_backpressure;
        halt = 1; jal = 1; imm32 = 32'h2; imem_ready = 1; inst_ready = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++; if (inst_valid !== 1'b1 || imem_req !== 1'b0 || retired !== 32'd9 || pc !== 32'h204 || inst !== 32'hC0DE_0204) begin
                n_fail++; $display("FAIL backpressure valid=%b req=%b retired=%h pc=%h inst=%h", inst_valid, imem_req, retired, pc, inst); end
        end
        clear_ctrl();
        imem_ready = 0;
        do_accept(0, 0, 0, 1, 32'h0, 32'h100, 0);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL bp_release req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
        do_fetch();
    endtask

    task automatic test_halt;
        do_accept(0, 0, 0, 0, 32'h0, 32'h0, 1);
        n_tests++; if (pc !== 32'h104 || imem_req !== 1'b0 || inst_valid !== 1'b0 || retired !== 32'd11) begin
            n_fail++; $display("FAIL halt_enter pc=%h req=%b valid=%b retired=%h exp 104/0/0/11", pc, imem_req, inst_valid, retired); end
        imem_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h104) begin
                n_fail++; $display("FAIL halt_stay req=%b valid=%b pc=%h exp 0/0/104", imem_req, inst_valid, pc); end
        end
        imem_ready = 0;
    endtask

    task automatic test_fault;
        rst = 1; #1 rst = 0;
        tick();
        do_fetch();
        n_tests++; if (inst_valid !== 1'b1 || pc !== 32'h100) begin
            n_fail++; $display("FAIL fault_boot valid=%b pc=%h exp 1/100", inst_valid, pc); end
        do_accept(0, 0, 1, 0, 32'h6, 32'h0, 1);
        n_tests++; if (misalign_fault !== 1'b1 || pc !== 32'h100 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL fault_enter fault=%b pc=%h req=%b valid=%b exp 1/100/0/0", misalign_fault, pc, imem_req, inst_valid); end
        imem_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (misalign_fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h100) begin
                n_fail++; $display("FAIL fault_sticky fault=%b req=%b pc=%h exp 1/0/100", misalign_fault, imem_req, pc); end
        end
        imem_ready = 0;
    endtask

    task automatic test_async_reset;
        rst = 1; #1 rst = 0;
        n_tests++; if (misalign_fault !== 1'b0 || retired !== 32'h0) begin
            n_fail++; $display("FAIL reset_clears fault=%b retired=%h exp 0/0", misalign_fault, retired); end
        tick();
        do_fetch();
        do_accept(0, 0, 0, 0, 32'h0, 32'h0, 0);
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            n_fail++; $display("FAIL pre_reset req=%b addr=%h exp 1/104", imem_req, imem_addr); end
        #3 rst = 1;
        #1;
        n_tests++; if (imem_req !== 1'b0 || pc !== 32'h100 || retired !== 32'h0 || inst !== 32'h0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_rst req=%b pc=%h retired=%h inst=%h valid=%b", imem_req, pc, retired, inst, inst_valid); end
        imem_ready = 1;
        tick(); tick();
        n_tests++; if (imem_req !== 1'b0 || inst !== 32'h0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_ignores_ready req=%b inst=%h valid=%b exp 0/0/0", imem_req, inst, inst_valid); end
        rst = 0;
        imem_ready = 0;
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL refetch req=%b addr=%h valid=%b exp 1/100/0", imem_req, imem_addr, inst_valid); end
    endtask

    initial begin
        imem_ready = 0;
        inst_ready = 0;
        clear_ctrl();
        test_reset();
        test_wait_states();
        test_branch();
        test_jumps();
        test_backpressure();
        test_halt();
        test_fault();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
